// File: rtl/err_compute_pkg.sv
// Shared types for the weighted IR error generator: input mode encoding and control FSM states.
package err_compute_pkg;

  typedef enum logic [1:0] {
    MODE_BOTH       = 2'b00,
    MODE_RIGHT_ONLY = 2'b01,
    MODE_LEFT_ONLY  = 2'b10
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ACCUM = 2'b01,
    ST_DONE  = 2'b10
  } state_e;

endpackage

// File: rtl/err_compute_gen_dp.sv
// Datapath: input snapshot, per-index term select/shift, signed accumulator and output saturator.
module err_compute_gen_dp
  import err_compute_pkg::*;
#(
  parameter int NUM_PAIRS = 4,
  parameter int IR_W      = 12,
  parameter int ERR_W     = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        i_start,
  input  logic                        i_step,
  input  logic                        i_load,
  input  logic [NUM_PAIRS*IR_W-1:0]   i_ir_r,
  input  logic [NUM_PAIRS*IR_W-1:0]   i_ir_l,
  input  logic [1:0]                  i_mode,
  output logic                        o_last,
  output logic signed [ERR_W-1:0]     o_error,
  output logic                        o_sat
);

  localparam int ACC_W = IR_W + NUM_PAIRS + 2;
  localparam int IDX_W = $clog2(2 * NUM_PAIRS);
  localparam int WIDE  = ((ACC_W > ERR_W) ? ACC_W : ERR_W) + 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(2 * NUM_PAIRS - 1);
  localparam logic signed [WIDE-1:0] SAT_HI = {{(WIDE-ERR_W+1){1'b0}}, {(ERR_W-1){1'b1}}};
  localparam logic signed [WIDE-1:0] SAT_LO = {{(WIDE-ERR_W+1){1'b1}}, {(ERR_W-1){1'b0}}};

  logic [NUM_PAIRS*IR_W-1:0] r_ir_r, r_ir_l;
  logic [1:0]                r_mode;
  logic signed [ACC_W-1:0]   r_acc;
  logic [IDX_W-1:0]          r_idx;
  logic signed [ERR_W-1:0]   r_error;
  logic                      r_sat;

  logic signed [ACC_W-1:0]   w_term;
  logic signed [ACC_W-1:0]   w_acc_nxt;
  logic                      w_en;
  logic signed [WIDE-1:0]    w_acc_x;
  logic signed [ERR_W-1:0]   w_sat_val;
  logic                      w_clip;

  // Even index: right reading of pair idx>>1 added; odd index: left reading subtracted.
  always_comb begin
    w_term = '0;
    for (int k = 0; k < NUM_PAIRS; k++) begin
      if ((r_idx >> 1) == IDX_W'(k)) begin
        w_term = r_idx[0] ? ({{(ACC_W-IR_W){1'b0}}, r_ir_l[k*IR_W +: IR_W]} << k)
                          : ({{(ACC_W-IR_W){1'b0}}, r_ir_r[k*IR_W +: IR_W]} << k);
      end
    end
    w_en = r_idx[0] ? (r_mode != MODE_RIGHT_ONLY) : (r_mode != MODE_LEFT_ONLY);
    if (!w_en) w_term = '0;
    w_acc_nxt = r_idx[0] ? (r_acc - w_term) : (r_acc + w_term);
  end

  always_comb begin
    w_acc_x   = {{(WIDE-ACC_W){r_acc[ACC_W-1]}}, r_acc};
    w_clip    = 1'b0;
    w_sat_val = w_acc_x[ERR_W-1:0];
    if (w_acc_x > SAT_HI) begin
      w_clip    = 1'b1;
      w_sat_val = SAT_HI[ERR_W-1:0];
    end else if (w_acc_x < SAT_LO) begin
      w_clip    = 1'b1;
      w_sat_val = SAT_LO[ERR_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ir_r  <= '0;
      r_ir_l  <= '0;
      r_mode  <= '0;
      r_acc   <= '0;
      r_idx   <= '0;
      r_error <= '0;
      r_sat   <= 1'b0;
    end else begin
      if (i_start) begin
        r_ir_r <= i_ir_r;
        r_ir_l <= i_ir_l;
        r_mode <= i_mode;
        r_acc  <= '0;
        r_idx  <= '0;
      end else if (i_step) begin
        r_acc <= w_acc_nxt;
        r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + IDX_W'(1);
      end
      if (i_load) begin
        r_error <= w_sat_val;
        r_sat   <= w_clip;
      end
    end
  end

  assign o_last  = (r_idx == IDX_LAST);
  assign o_error = r_error;
  assign o_sat   = r_sat;

endmodule

// File: rtl/err_compute_gen.sv
// Weighted left/right IR error generator: control FSM sequencing one term per cycle through the datapath.
//   state    | meaning
//   ST_IDLE  | waiting for IR_vld; snapshot taken on acceptance
//   ST_ACCUM | one weighted term accumulated per cycle
//   ST_DONE  | saturated result loaded, err_vld pulsed
module err_compute_gen
  import err_compute_pkg::*;
#(
  parameter int NUM_PAIRS = 4,
  parameter int IR_W      = 12,
  parameter int ERR_W     = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        IR_vld,
  input  logic [1:0]                  mode,
  input  logic [NUM_PAIRS*IR_W-1:0]   IR_R,
  input  logic [NUM_PAIRS*IR_W-1:0]   IR_L,
  output logic signed [ERR_W-1:0]     error,
  output logic                        err_vld,
  output logic                        err_sat,
  output logic                        err_ovr
);

  state_e r_state, w_state_nxt;
  logic   r_err_vld, r_err_ovr;
  logic   w_start, w_step, w_load, w_busy, w_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (IR_vld) w_state_nxt = ST_ACCUM;
      ST_ACCUM: if (w_last) w_state_nxt = ST_DONE;
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_start = (r_state == ST_IDLE) && IR_vld;
    w_step  = (r_state == ST_ACCUM);
    w_load  = (r_state == ST_DONE);
    w_busy  = (r_state != ST_IDLE);
  end

  // Strobes are registered so they line up with the error register update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_vld <= 1'b0;
      r_err_ovr <= 1'b0;
    end else begin
      r_err_vld <= w_load;
      r_err_ovr <= IR_vld && w_busy;
    end
  end

  err_compute_gen_dp #(
    .NUM_PAIRS (NUM_PAIRS),
    .IR_W      (IR_W),
    .ERR_W     (ERR_W)
  ) u_dp (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_start (w_start),
    .i_step  (w_step),
    .i_load  (w_load),
    .i_ir_r  (IR_R),
    .i_ir_l  (IR_L),
    .i_mode  (mode),
    .o_last  (w_last),
    .o_error (error),
    .o_sat   (err_sat)
  );

  assign err_vld = r_err_vld;
  assign err_ovr = r_err_ovr;

endmodule

// File: tb/tb_err_compute_gen.sv
// Directed bench for err_compute_gen at NUM_PAIRS=4 and NUM_PAIRS=8 with hand-computed results.
module tb_err_compute_gen;
  import err_compute_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic              a_vld;
  logic [1:0]        a_mode;
  logic [47:0]       a_ir_r, a_ir_l;
  logic signed [15:0] a_error;
  logic              a_err_vld, a_err_sat, a_err_ovr;

  logic              b_vld;
  logic [1:0]        b_mode;
  logic [95:0]       b_ir_r, b_ir_l;
  logic signed [15:0] b_error;
  logic              b_err_vld, b_err_sat, b_err_ovr;

  int n_asrt = 0;
  int n_fail = 0;
  int lat;
  int cnt;

  err_compute_gen #(.NUM_PAIRS(4), .IR_W(12), .ERR_W(16)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .IR_vld(a_vld), .mode(a_mode), .IR_R(a_ir_r), .IR_L(a_ir_l),
    .error(a_error), .err_vld(a_err_vld), .err_sat(a_err_sat), .err_ovr(a_err_ovr)
  );

  err_compute_gen #(.NUM_PAIRS(8), .IR_W(12), .ERR_W(16)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .IR_vld(b_vld), .mode(b_mode), .IR_R(b_ir_r), .IR_L(b_ir_l),
    .error(b_error), .err_vld(b_err_vld), .err_sat(b_err_sat), .err_ovr(b_err_ovr)
  );

  function automatic logic [47:0] rep4(input logic [11:0] v);
    return {4{v}};
  endfunction

  function automatic logic [95:0] rep8(input logic [11:0] v);
    return {8{v}};
  endfunction

  task automatic check(input string tag, input int obs, input int exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic start_a(input logic [1:0] m, input logic [47:0] r, input logic [47:0] l);
    @(negedge clk);
    a_vld = 1'b1; a_mode = m; a_ir_r = r; a_ir_l = l;
    @(negedge clk);
    a_vld = 1'b0;
  endtask

  task automatic start_b(input logic [1:0] m, input logic [95:0] r, input logic [95:0] l);
    @(negedge clk);
    b_vld = 1'b1; b_mode = m; b_ir_r = r; b_ir_l = l;
    @(negedge clk);
    b_vld = 1'b0;
  endtask

  // Returns the edge number (acceptance edge = 0) at which err_vld is seen, or -1.
  task automatic wait_a(input bit scramble, output int l);
    l = -1;
    for (int n = 1; n <= 25; n++) begin
      if (scramble) begin
        a_ir_r = {$urandom(), 16'($urandom())};
        a_ir_l = {$urandom(), 16'($urandom())};
        a_mode = 2'($urandom());
      end
      @(posedge clk); #1;
      if (a_err_vld) begin
        l = n;
        break;
      end
    end
  endtask

  task automatic wait_b(output int l);
    l = -1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (b_err_vld) begin
        l = n;
        break;
      end
    end
  endtask

  initial begin
    a_vld = 1'b0; a_mode = 2'b00; a_ir_r = '0; a_ir_l = '0;
    b_vld = 1'b0; b_mode = 2'b00; b_ir_r = '0; b_ir_l = '0;
    repeat (3) @(negedge clk);
    check("rst_error", a_error, 0);
    check("rst_sat", a_err_sat, 0);
    check("rst_vld", a_err_vld, 0);
    check("rst_ovr", a_err_ovr, 0);
    check("rst_error8", b_error, 0);
    rst_n = 1'b1;

    start_a(MODE_BOTH, rep4(12'd100), rep4(12'd0));
    wait_a(1'b0, lat);
    check("both_lat", lat, 9);
    check("both_err", a_error, 1500);
    check("both_sat", a_err_sat, 0);

    start_a(MODE_LEFT_ONLY, rep4(12'd100), rep4(12'd50));
    check("vld_pulse_end", a_err_vld, 0);
    check("hold_b2b", a_error, 1500);
    wait_a(1'b0, lat);
    check("left_lat_b2b", lat, 9);
    check("left_err", a_error, -750);
    check("left_sat", a_err_sat, 0);

    start_a(MODE_RIGHT_ONLY, rep4(12'd100), rep4(12'd50));
    wait_a(1'b0, lat);
    check("right_lat", lat, 9);
    check("right_err", a_error, 1500);

    start_a(2'b11, rep4(12'd100), rep4(12'd50));
    wait_a(1'b0, lat);
    check("mode3_err", a_error, 750);

    repeat (5) @(negedge clk);
    check("hold_err", a_error, 750);
    check("hold_vld", a_err_vld, 0);

    start_a(MODE_BOTH, rep4(12'd200), rep4(12'd10));
    @(negedge clk);
    @(negedge clk);
    a_vld = 1'b1; a_ir_r = rep4(12'd1); a_ir_l = '0;
    @(posedge clk); #1;
    check("ovr_pulse", a_err_ovr, 1);
    @(negedge clk);
    a_vld = 1'b0;
    @(posedge clk); #1;
    check("ovr_clear", a_err_ovr, 0);
    lat = -1;
    for (int n = 5; n <= 25; n++) begin
      @(posedge clk); #1;
      if (a_err_vld) begin
        lat = n;
        break;
      end
    end
    check("ovr_lat", lat, 9);
    check("ovr_err", a_error, 2850);
    cnt = 0;
    repeat (15) begin
      @(posedge clk); #1;
      if (a_err_vld) cnt++;
    end
    check("ovr_single_vld", cnt, 0);

    start_a(MODE_BOTH, rep4(12'd300), rep4(12'd100));
    wait_a(1'b1, lat);
    check("snap_lat", lat, 9);
    check("snap_err", a_error, 3000);
    a_mode = 2'b00; a_ir_r = '0; a_ir_l = '0;

    start_a(MODE_BOTH, rep4(12'd100), rep4(12'd0));
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_err", a_error, 0);
    check("midrst_sat", a_err_sat, 0);
    check("midrst_vld", a_err_vld, 0);
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (a_err_vld) cnt++;
    end
    check("midrst_no_vld", cnt, 0);
    start_a(MODE_LEFT_ONLY, rep4(12'd7), rep4(12'd3));
    wait_a(1'b0, lat);
    check("postrst_lat", lat, 9);
    check("postrst_err", a_error, -45);

    start_b(MODE_BOTH, rep8(12'd1), rep8(12'd0));
    wait_b(lat);
    check("p8_lat", lat, 17);
    check("p8_small_err", b_error, 255);
    check("p8_small_sat", b_err_sat, 0);

    start_b(MODE_BOTH, rep8(12'hFFF), rep8(12'd0));
    wait_b(lat);
    check("p8_pos_err", b_error, 32767);
    check("p8_pos_sat", b_err_sat, 1);

    start_b(MODE_BOTH, rep8(12'd0), rep8(12'hFFF));
    wait_b(lat);
    check("p8_neg_err", b_error, -32768);
    check("p8_neg_sat", b_err_sat, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule

// File: doc/err_compute_gen.md
ERR_COMPUTE_GEN -- requirements
Module: err_compute_gen

Interface
REQ-001 SHALL have parameter NUM_PAIRS, default 4, number of IR sensor pairs (legal 1..8).
REQ-002 SHALL have parameter IR_W, default 12, unsigned width of each IR reading.
REQ-003 SHALL have parameter ERR_W, default 16, signed width of error output.
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port IR_vld  input  1  one-cycle strobe: new readings present.
REQ-007 SHALL have port mode  input  2  00 BOTH, 01 RIGHT_ONLY, 10 LEFT_ONLY, 11 treated as BOTH.
REQ-008 SHALL have port IR_R  input  NUM_PAIRS*IR_W  packed right readings, pair k at bits [k*IR_W +: IR_W].
REQ-009 SHALL have port IR_L  input  NUM_PAIRS*IR_W  packed left readings, same packing.
REQ-010 SHALL have port error  output  ERR_W  signed registered weighted error.
REQ-011 SHALL have port err_vld  output  1  one-cycle pulse when error updates.
REQ-012 SHALL have port err_sat  output  1  registered with error; 1 when last result was clipped.
REQ-013 SHALL have port err_ovr  output  1  one-cycle pulse when IR_vld arrives while busy.

Function
REQ-014 SHALL compute error = sat( sum over k of 2^k * (mR*IR_R[k] - mL*IR_L[k]) ), mR=0 in LEFT_ONLY else 1, mL=0 in RIGHT_ONLY else 1.
REQ-015 SHALL use FSM states IDLE, ACCUM, DONE.
REQ-016 SHALL, on edge with IR_vld=1 in IDLE, snapshot IR_R, IR_L, mode into internal registers, clear accumulator, index=0, go ACCUM.
REQ-017 SHALL, in ACCUM, process one term per cycle, index i = 0..2*NUM_PAIRS-1: pair k=i>>1, even i adds R term, odd i subtracts L term, term = reading << k, masked to 0 per mode.
REQ-018 SHALL go ACCUM -> DONE on the edge processing i = 2*NUM_PAIRS-1.
REQ-019 SHALL, on the DONE edge, load error and err_sat, assert err_vld for exactly one cycle, return to IDLE.
REQ-020 SHALL give latency: IR_vld sampled at edge 0 -> err_vld high from edge 2*NUM_PAIRS+1 for one cycle (9 cycles at NUM_PAIRS=4).
REQ-021 SHALL use signed accumulator of IR_W+NUM_PAIRS+2 bits; no internal overflow possible.
REQ-022 SHALL saturate to [-2^(ERR_W-1), 2^(ERR_W-1)-1] and set err_sat=1 only when clipping occurred.
REQ-023 SHALL ignore input changes after the snapshot edge until next accepted IR_vld.
REQ-024 SHALL ignore IR_vld in ACCUM or DONE, pulse err_ovr one cycle, leave in-progress result unaffected.
REQ-025 SHALL hold error and err_sat between updates.
REQ-026 SHALL accept IR_vld in IDLE on the cycle immediately after err_vld (back-to-back throughput 2*NUM_PAIRS+2 cycles).

Reset
REQ-027 SHALL, on rst_n low, asynchronously force state IDLE, error=0, err_sat=0, err_vld=0, err_ovr=0, accumulator and index=0.
REQ-028 SHALL discard an in-progress computation on reset mid-ACCUM/DONE; no err_vld after release until a new IR_vld.

Structure
REQ-029 SHALL place mode enum (BOTH, RIGHT_ONLY, LEFT_ONLY) and state enum in shared package err_compute_pkg.
REQ-030 SHALL split into control FSM and datapath sub-module err_compute_gen_dp (snapshot regs, term mux/shift, accumulator, saturator).

Verification
REQ-031 SHALL cover: NUM_PAIRS=4, BOTH, all R=100, L=0 -> error=1500, err_sat=0, err_vld exactly 9 cycles after IR_vld.
REQ-032 SHALL cover: NUM_PAIRS=4, LEFT_ONLY, R=100, L=50 -> error=-750; RIGHT_ONLY same inputs -> 1500.
REQ-033 SHALL cover: NUM_PAIRS=8, BOTH, all R=4095, L=0 -> error=32767, err_sat=1; swapped -> -32768, err_sat=1.
REQ-034 SHALL cover: second IR_vld 3 cycles after first -> err_ovr one-cycle pulse, single err_vld with first-sample result.
REQ-035 SHALL cover: inputs changed every cycle after capture -> result equals snapshot value.
REQ-036 SHALL cover: rst_n low during ACCUM -> outputs 0, no err_vld; next IR_vld yields correct result.
